// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
// States, item codes and the price table live here.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DISPENSE,
    CHANGE
  } state_t;

  typedef enum logic [1:0] {
    PIZZA   = 2'd0,
    BURGUER = 2'd1,
    TORTA   = 2'd2,
    SODA    = 2'd3
  } item_t;

  localparam logic [3:0] PRICE_PIZZA   = 4'd8;
  localparam logic [3:0] PRICE_BURGUER = 4'd6;
  localparam logic [3:0] PRICE_TORTA   = 4'd5;
  localparam logic [3:0] PRICE_SODA    = 4'd3;

  function automatic logic [3:0] price(input logic [1:0] item);
    logic [3:0] p;
    unique case (item)
      PIZZA:   p = PRICE_PIZZA;
      BURGUER: p = PRICE_BURGUER;
      TORTA:   p = PRICE_TORTA;
      default: p = PRICE_SODA;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the dispense hold and idle timeout.
// done is high while the count sits at zero.
module vend_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Coin-operated vending sequencer: credit, select, dispense, refund.
// Refund path and idle timeout are enabled by CHANGE_RETURN_EN.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int BAL_W          = 6,
  parameter int DISP_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             coin_valid,
  input  logic [BAL_W-1:0] coin_value,
  input  logic             sel_valid,
  input  logic [1:0]       sel_item,
  input  logic             cancel,
  output logic [BAL_W-1:0] balance,
  output logic             busy,
  output logic [3:0]       dispense,
  output logic             sucesso,
  output logic             fail,
  output logic             coin_reject,
  output logic             change_valid,
  output logic [BAL_W-1:0] change_value
);

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BAL_W-1:0] BAL_MAX   = '1;

  state_t           state, state_n;
  logic [BAL_W-1:0] bal_q, bal_n, bal_add, cost;
  logic [BAL_W:0]   sum;
  logic [1:0]       item_q, item_n;
  logic             reject_q, reject_n;
  logic             t_load, t_en, t_done;
  logic [CNT_W-1:0] t_value;

  assign sum     = {1'b0, bal_q} + {1'b0, coin_value};
  assign bal_add = sum[BAL_W] ? BAL_MAX : sum[BAL_W-1:0];
  assign cost    = BAL_W'(price(item_q));

  vend_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (t_load),
    .value  (t_value),
    .enable (t_en),
    .done   (t_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bal_q    <= '0;
      item_q   <= 2'd0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_n;
      bal_q    <= bal_n;
      item_q   <= item_n;
      reject_q <= reject_n;
    end
  end

  always_comb begin
    state_n      = state;
    bal_n        = bal_q;
    item_n       = item_q;
    reject_n     = 1'b0;
    t_load       = 1'b0;
    t_value      = TMO_LOAD;
    t_en         = 1'b0;
    sucesso      = 1'b0;
    fail         = 1'b0;
    dispense     = 4'b0000;
    change_valid = 1'b0;
    change_value = '0;
    unique case (state)
      IDLE: begin
        if (coin_valid) bal_n = bal_add;
        // cancel wins over a same-cycle selection in both builds
        if (cancel) begin
`ifdef CHANGE_RETURN_EN
          if (bal_n != '0) state_n = CHANGE;
`endif
        end else if (sel_valid) begin
          item_n  = sel_item;
          state_n = CHECK;
        end
        if (coin_valid || sel_valid || cancel || bal_q == '0) begin
          t_load = 1'b1;
        end else begin
          t_en = 1'b1;
`ifdef CHANGE_RETURN_EN
          if (t_done) state_n = CHANGE;
`endif
        end
      end
      CHECK: begin
        reject_n = coin_valid;
        t_load   = 1'b1;
        if (bal_q >= cost) begin
          bal_n   = bal_q - cost;
          sucesso = 1'b1;
          t_value = DISP_LOAD;
          state_n = DISPENSE;
        end else begin
          fail    = 1'b1;
          state_n = IDLE;
        end
      end
      DISPENSE: begin
        reject_n = coin_valid;
        dispense = 4'b0001 << item_q;
        t_en     = 1'b1;
        if (t_done) begin
`ifdef CHANGE_RETURN_EN
          state_n = CHANGE;
`else
          state_n = IDLE;
`endif
        end
      end
      CHANGE: begin
        reject_n = coin_valid;
`ifdef CHANGE_RETURN_EN
        change_valid = 1'b1;
        change_value = bal_q;
`endif
        bal_n   = '0;
        t_load  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign balance     = bal_q;
  assign busy        = (state != IDLE);
  assign coin_reject = reject_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer (short timer parameters).
// Expectations follow the build's CHANGE_RETURN_EN setting.
module tb_vend_sequencer;

  localparam int BAL_W = 6;
  localparam int DISP  = 4;
  localparam int TMO   = 30;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             coin_valid = 1'b0;
  logic [BAL_W-1:0] coin_value = '0;
  logic             sel_valid = 1'b0;
  logic [1:0]       sel_item = 2'd0;
  logic             cancel = 1'b0;
  logic [BAL_W-1:0] balance;
  logic             busy;
  logic [3:0]       dispense;
  logic             sucesso;
  logic             fail;
  logic             coin_reject;
  logic             change_valid;
  logic [BAL_W-1:0] change_value;

  int checks = 0;
  int failures = 0;

  vend_sequencer #(
    .BAL_W(BAL_W),
    .DISP_CYCLES(DISP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .sel_valid(sel_valid),
    .sel_item(sel_item),
    .cancel(cancel),
    .balance(balance),
    .busy(busy),
    .dispense(dispense),
    .sucesso(sucesso),
    .fail(fail),
    .coin_reject(coin_reject),
    .change_valid(change_valid),
    .change_value(change_value)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    coin_valid = 0; sel_valid = 0; cancel = 0;
    coin_value = '0; sel_item = 2'd0;
    reset = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
  endtask

  task automatic coin(input int v);
    coin_valid = 1; coin_value = BAL_W'(v);
    tick();
    coin_valid = 0; coin_value = '0;
  endtask

  task automatic select(input logic [1:0] it);
    sel_valid = 1; sel_item = it;
    tick();
    sel_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({balance, busy, dispense} !== {6'd0, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL reset_state got bal=%0d busy=%b disp=%b exp 0/0/0000",
               balance, busy, dispense);
    end
    checks++;
    if ({sucesso, fail, coin_reject, change_valid, change_value} !== 10'd0) begin
      failures++;
      $display("FAIL reset_pulses got suc=%b fail=%b rej=%b cv=%b cval=%0d exp all 0",
               sucesso, fail, coin_reject, change_valid, change_value);
    end
  endtask

  task automatic test_purchase();
    apply_reset();
    coin(5);
    coin(5);
    checks++;
    if (balance !== 6'd10) begin
      failures++;
      $display("FAIL buy_credit got=%0d exp=10", balance);
    end
    select(2'd0);
    checks++;
    if ({sucesso, fail, busy} !== 3'b101) begin
      failures++;
      $display("FAIL buy_check got suc=%b fail=%b busy=%b exp 1/0/1", sucesso, fail, busy);
    end
    tick();
    checks++;
    if (balance !== 6'd2) begin
      failures++;
      $display("FAIL buy_balance got=%0d exp=2", balance);
    end
    for (int i = 0; i < DISP; i++) begin
      checks++;
      if (dispense !== 4'b0001 || sucesso !== 1'b0) begin
        failures++;
        $display("FAIL buy_dispense cyc=%0d got disp=%b suc=%b exp 0001/0", i, dispense, sucesso);
      end
      tick();
    end
    checks++;
    if (dispense !== 4'b0000) begin
      failures++;
      $display("FAIL buy_disp_end got=%b exp=0000", dispense);
    end
`ifdef CHANGE_RETURN_EN
    checks++;
    if ({change_valid, change_value} !== {1'b1, 6'd2}) begin
      failures++;
      $display("FAIL buy_change got cv=%b val=%0d exp 1/2", change_valid, change_value);
    end
    tick();
    checks++;
    if ({balance, busy, change_valid, change_value} !== {6'd0, 1'b0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL buy_after got bal=%0d busy=%b cv=%b val=%0d exp 0/0/0/0",
               balance, busy, change_valid, change_value);
    end
`else
    checks++;
    if ({balance, busy, change_valid, change_value} !== {6'd2, 1'b0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL buy_after got bal=%0d busy=%b cv=%b val=%0d exp 2/0/0/0",
               balance, busy, change_valid, change_value);
    end
`endif
  endtask

  task automatic test_fail();
    apply_reset();
    coin(4);
    select(2'd0);
    checks++;
    if ({sucesso, fail} !== 2'b01) begin
      failures++;
      $display("FAIL short_pulse got suc=%b fail=%b exp 0/1", sucesso, fail);
    end
    tick();
    checks++;
    if ({balance, busy, dispense, fail} !== {6'd4, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL short_after got bal=%0d busy=%b disp=%b fail=%b exp 4/0/0000/0",
               balance, busy, dispense, fail);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    coin(60);
    checks++;
    if (balance !== 6'd60) begin
      failures++;
      $display("FAIL sat_first got=%0d exp=60", balance);
    end
    coin(10);
    checks++;
    if (balance !== 6'd63) begin
      failures++;
      $display("FAIL sat_clip got=%0d exp=63", balance);
    end
  endtask

  task automatic test_reject();
    apply_reset();
    coin(8);
    select(2'd3);
    tick();
    checks++;
    if ({dispense, balance} !== {4'b1000, 6'd5}) begin
      failures++;
      $display("FAIL rej_enter got disp=%b bal=%0d exp 1000/5", dispense, balance);
    end
    coin(3);
    checks++;
    if ({coin_reject, balance} !== {1'b1, 6'd5}) begin
      failures++;
      $display("FAIL rej_pulse got rej=%b bal=%0d exp 1/5", coin_reject, balance);
    end
    tick();
    checks++;
    if (coin_reject !== 1'b0) begin
      failures++;
      $display("FAIL rej_clear got=%b exp=0", coin_reject);
    end
    repeat (2) tick();
`ifdef CHANGE_RETURN_EN
    checks++;
    if ({change_valid, change_value} !== {1'b1, 6'd5}) begin
      failures++;
      $display("FAIL rej_change got cv=%b val=%0d exp 1/5", change_valid, change_value);
    end
`else
    checks++;
    if ({busy, balance} !== {1'b0, 6'd5}) begin
      failures++;
      $display("FAIL rej_idle got busy=%b bal=%0d exp 0/5", busy, balance);
    end
`endif
  endtask

  task automatic test_cancel_priority();
    apply_reset();
    coin(7);
    cancel = 1; sel_valid = 1; sel_item = 2'd3;
    tick();
    cancel = 0; sel_valid = 0;
    checks++;
    if ({sucesso, fail} !== 2'b00) begin
      failures++;
      $display("FAIL cancel_nosel got suc=%b fail=%b exp 0/0", sucesso, fail);
    end
`ifdef CHANGE_RETURN_EN
    checks++;
    if ({change_valid, change_value} !== {1'b1, 6'd7}) begin
      failures++;
      $display("FAIL cancel_change got cv=%b val=%0d exp 1/7", change_valid, change_value);
    end
    tick();
    checks++;
    if ({balance, busy} !== {6'd0, 1'b0}) begin
      failures++;
      $display("FAIL cancel_after got bal=%0d busy=%b exp 0/0", balance, busy);
    end
    cancel = 1;
    tick();
    cancel = 0;
    checks++;
    if ({busy, change_valid} !== 2'b00) begin
      failures++;
      $display("FAIL cancel_zero got busy=%b cv=%b exp 0/0", busy, change_valid);
    end
`else
    checks++;
    if ({busy, change_valid, balance} !== {1'b0, 1'b0, 6'd7}) begin
      failures++;
      $display("FAIL cancel_noop got busy=%b cv=%b bal=%0d exp 0/0/7",
               busy, change_valid, balance);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    coin_valid = 1; coin_value = 6'd3; sel_valid = 1; sel_item = 2'd3;
    tick();
    coin_valid = 0; sel_valid = 0;
    checks++;
    if ({sucesso, fail, balance} !== {1'b1, 1'b0, 6'd3}) begin
      failures++;
      $display("FAIL b2b_check got suc=%b fail=%b bal=%0d exp 1/0/3", sucesso, fail, balance);
    end
    tick();
    checks++;
    if ({dispense, balance} !== {4'b1000, 6'd0}) begin
      failures++;
      $display("FAIL b2b_disp got disp=%b bal=%0d exp 1000/0", dispense, balance);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    coin(3);
    repeat (TMO - 1) tick();
    checks++;
    if ({busy, balance} !== {1'b0, 6'd3}) begin
      failures++;
      $display("FAIL tmo_wait got busy=%b bal=%0d exp 0/3", busy, balance);
    end
    tick();
`ifdef CHANGE_RETURN_EN
    checks++;
    if ({change_valid, change_value} !== {1'b1, 6'd3}) begin
      failures++;
      $display("FAIL tmo_fire got cv=%b val=%0d exp 1/3", change_valid, change_value);
    end
`else
    repeat (10) tick();
    checks++;
    if ({busy, change_valid, balance} !== {1'b0, 1'b0, 6'd3}) begin
      failures++;
      $display("FAIL tmo_off got busy=%b cv=%b bal=%0d exp 0/0/3", busy, change_valid, balance);
    end
`endif
  endtask

  task automatic test_reset_mid_dispense();
    apply_reset();
    coin(8);
    select(2'd3);
    tick();
    checks++;
    if (dispense !== 4'b1000) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=1000", dispense);
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({dispense, balance, busy} !== {4'd0, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_async got disp=%b bal=%0d busy=%b exp 0000/0/0",
               dispense, balance, busy);
    end
    #10 reset = 1;
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_fail();
    test_saturate();
    test_reject();
    test_cancel_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_dispense();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
